// File: rtl/imem_prog.sv
// imem_prog: loadable instruction memory with a registered fetch port.
// After reset the array is swept to DEFAULT_INSTR. Once the sweep is done,
// words can be written through the load port and read through the fetch port.
module imem_prog #(
    parameter int unsigned          DATA_W        = 32,
    parameter int unsigned          ADDR_W        = 4,
    parameter logic [DATA_W-1:0]    DEFAULT_INSTR = 32'hEAFF_FFFE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [ADDR_W-1:0]   clr_cnt_next;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [ADDR_W-1:0]   widx;
    logic                fetch_bad;
    logic                fetch_go;

    assign busy     = (state == CLEAR);
    assign if_ready = ~busy;

    // State and sweep counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= next_state;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Next-state logic and single write port arbitration (sweep or loader).
    always_comb begin
        next_state   = state;
        clr_cnt_next = clr_cnt;
        mem_we       = 1'b0;
        mem_waddr    = ld_addr;
        mem_wdata    = ld_data;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = DEFAULT_INSTR;
                if (clr_cnt == '1) begin
                    next_state = RUN;
                end else begin
                    clr_cnt_next = clr_cnt + 1'b1;
                end
            end
            RUN: begin
                mem_we = ld_en;
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
    end

    // Memory array write; contents are not reset, the sweep overwrites them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Fetch address decode: word index plus range/alignment fault check.
    always_comb begin
        widx      = if_addr[ADDR_W+1:2];
        fetch_bad = ((if_addr >> (ADDR_W + 2)) != '0) || (if_addr[1:0] != 2'b00);
        fetch_go  = if_req && (state == RUN);
    end

    // Registered fetch response; reads the pre-write word on a same-cycle load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_fault <= 1'b0;
            if_rdata <= DEFAULT_INSTR;
        end else if (fetch_go) begin
            if_valid <= 1'b1;
            if_fault <= fetch_bad;
            if_rdata <= fetch_bad ? DEFAULT_INSTR : mem[widx];
        end else begin
            if_valid <= 1'b0;
            if_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_prog.sv
// tb_imem_prog: directed self-checking bench for imem_prog.
module tb_imem_prog;

    localparam logic [31:0] DEF = 32'hEAFF_FFFE;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_fault;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic        busy;

    int vectors;
    int miscompares;
    int cnt;

    imem_prog #(
        .DATA_W        (32),
        .ADDR_W        (4),
        .DEFAULT_INSTR (32'hEAFF_FFFE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .if_fault (if_fault),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .busy     (busy)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
        tick();
        if_req  = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;

        // Reset values while reset is held.
        repeat (3) tick();
        chk("rst_busy",   {31'd0, busy},     32'd1);
        chk("rst_ready",  {31'd0, if_ready}, 32'd0);
        chk("rst_valid",  {31'd0, if_valid}, 32'd0);
        chk("rst_fault",  {31'd0, if_fault}, 32'd0);
        chk("rst_rdata",  if_rdata,          DEF);

        // Sweep: busy for 16 cycles; requests and a load are ignored meanwhile.
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h3C;
        cnt = 0;
        while (busy && cnt < 40) begin
            ld_en   = (cnt == 13);
            ld_addr = 4'd2;
            ld_data = 32'h1234_5678;
            cnt++;
            tick();
            chk("sweep_valid", {31'd0, if_valid}, 32'd0);
        end
        ld_en = 1'b0;
        chk("sweep_len",   cnt,               32'd16);
        chk("run_ready",   {31'd0, if_ready}, 32'd1);
        tick();
        if_req = 1'b0;
        chk("f3c_valid",   {31'd0, if_valid}, 32'd1);
        chk("f3c_rdata",   if_rdata,          DEF);
        chk("f3c_fault",   {31'd0, if_fault}, 32'd0);

        // Load then back-to-back fetch.
        load(4'd0, 32'hE202_2000);
        load(4'd4, 32'hEA00_0005);
        if_req  = 1'b1;
        if_addr = 32'h00;
        tick();
        chk("b2b0_valid", {31'd0, if_valid}, 32'd1);
        chk("b2b0_rdata", if_rdata,          32'hE202_2000);
        if_addr = 32'h10;
        tick();
        if_req = 1'b0;
        chk("b2b1_valid", {31'd0, if_valid}, 32'd1);
        chk("b2b1_rdata", if_rdata,          32'hEA00_0005);
        chk("b2b1_fault", {31'd0, if_fault}, 32'd0);
        tick();
        chk("idle_valid", {31'd0, if_valid}, 32'd0);
        chk("idle_hold",  if_rdata,          32'hEA00_0005);

        // Same-cycle load and fetch: read-first.
        load(4'd5, 32'hE082_2004);
        ld_en   = 1'b1;
        ld_addr = 4'd5;
        ld_data = 32'h1AFF_FFFB;
        if_req  = 1'b1;
        if_addr = 32'h14;
        tick();
        ld_en = 1'b0;
        chk("coll_old", if_rdata, 32'hE082_2004);
        tick();
        if_req = 1'b0;
        chk("coll_new", if_rdata, 32'h1AFF_FFFB);

        // Faults: out of range and misaligned.
        fetch(32'h40);
        chk("oor_valid", {31'd0, if_valid}, 32'd1);
        chk("oor_rdata", if_rdata,          DEF);
        chk("oor_fault", {31'd0, if_fault}, 32'd1);
        fetch(32'h06);
        chk("mis_rdata", if_rdata,          DEF);
        chk("mis_fault", {31'd0, if_fault}, 32'd1);
        fetch(32'h8000_0000);
        chk("hi_fault",  {31'd0, if_fault}, 32'd1);
        fetch(32'h00);
        chk("ok_fault",  {31'd0, if_fault}, 32'd0);
        chk("ok_rdata",  if_rdata,          32'hE202_2000);
        tick();
        chk("idle_fault", {31'd0, if_fault}, 32'd0);

        // Load issued during the sweep was dropped.
        fetch(32'h08);
        chk("drop_rdata", if_rdata,          DEF);
        chk("drop_fault", {31'd0, if_fault}, 32'd0);

        // Mid-operation reset on the response cycle.
        load(4'd1, 32'hA5A5_0001);
        fetch(32'h04);
        chk("pre_valid", {31'd0, if_valid}, 32'd1);
        chk("pre_rdata", if_rdata,          32'hA5A5_0001);
        reset = 1'b1;
        #1;
        chk("mrst_valid", {31'd0, if_valid}, 32'd0);
        chk("mrst_busy",  {31'd0, busy},     32'd1);
        chk("mrst_rdata", if_rdata,          DEF);
        repeat (2) tick();
        reset = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("sweep2_len", cnt, 32'd16);
        fetch(32'h04);
        chk("after_w1",   if_rdata,          DEF);
        chk("after_f1",   {31'd0, if_fault}, 32'd0);
        fetch(32'h00);
        chk("after_w0",   if_rdata,          DEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_prog.md
Name: imem_prog

Overview:
Parametrised, loadable instruction memory; successor to the fixed-program ROM on the processor fetch path.
- Program words are written at run time through a load port, e.g. by a testbench or boot loader. After reset the block sweeps the array to a safe default instruction.
- The fetch port is a registered request/valid interface. Reads complete one cycle after the request and carry a fault flag for bad addresses.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 4, word-index width; DEPTH = 2**ADDR_W words.
- DEFAULT_INSTR, 32'hEAFF_FFFE, fill value and fault return value (branch-to-self).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; sampled only when if_ready=1.
- if_addr  in  32  byte address of the fetch.
- if_ready  out  1  fetch port can accept; equals ~busy.
- if_valid  out  1  if_rdata/if_fault valid this cycle.
- if_rdata  out  DATA_W  fetched instruction.
- if_fault  out  1  accompanies if_valid; the address was out of range or misaligned.
- ld_en  in  1  load-word strobe; honoured only when busy=0.
- ld_addr  in  ADDR_W  word index to write.
- ld_data  in  DATA_W  word to write.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset is asynchronous and active-high.
  - While reset=1: state=CLEAR, clr_cnt=0, busy=1, if_ready=0, if_valid=0, if_fault=0, if_rdata=DEFAULT_INSTR.
  - Array contents are not reset directly; the sweep overwrites them.
- The state machine has two states, CLEAR and RUN.
  - CLEAR: each cycle writes DEFAULT_INSTR to mem[clr_cnt] and increments clr_cnt.
  - When clr_cnt==DEPTH-1 is written, go to RUN. The sweep takes exactly DEPTH cycles after reset deasserts.
  - In RUN, busy deasserts on the first RUN cycle.
  - RUN is held until the next reset. There is no other path back to CLEAR.
- Load port:
  - In RUN, ld_en=1 writes mem[ld_addr]<=ld_data at the clock edge.
  - In CLEAR, ld_en is ignored and the word is dropped; the loader must wait for busy=0.
- Fetch, in RUN with if_req=1: the request is accepted and the response appears the next cycle with if_valid=1. Latency is 1, with a throughput of one fetch per cycle.
  - widx = if_addr[ADDR_W+1:2].
  - Out of range means if_addr[31:ADDR_W+2] != 0. Misaligned means if_addr[1:0] != 0.
  - On either condition: if_rdata=DEFAULT_INSTR and if_fault=1.
  - Otherwise: if_rdata=mem[widx] and if_fault=0.
- When if_req=0 or busy=1, the next cycle has if_valid=0 and if_fault=0. if_rdata holds its last value.
- A load and a fetch of the same word in the same cycle is read-first: the fetch returns the old word, and the new word is visible from the next fetch.
- Reset during CLEAR or RUN aborts everything, drops any in-flight fetch (if_valid=0), and restarts the full sweep.
- clr_cnt is ADDR_W bits wide and saturates at DEPTH-1 in RUN; it does not wrap.

Test Plan:
1. Reset sweep:
   - Stimulus: hold reset 3 cycles, then release with DEPTH=16.
   - Required: busy=1 for exactly 16 cycles, then 0. A fetch of 0x3C returns 32'hEAFF_FFFE with if_fault=0.
2. Load then fetch:
   - Stimulus: in RUN, ld_addr=0 ld_data=32'hE202_2000, then ld_addr=4 ld_data=32'hEA00_0005. Then fetch 0x00, 0x10 back-to-back.
   - Required: if_valid high on two consecutive cycles, returning E2022000 then EA000005, with latency 1.
3. Collision:
   - Stimulus: mem[5]=32'hE082_2004. In the same cycle, ld_en with ld_addr=5 ld_data=32'h1AFF_FFFB and fetch 0x14. Fetch 0x14 again the next cycle.
   - Required: first response E0822004 (read-first), second response 1AFFFFFB.
4. Faults:
   - Stimulus: fetch 0x40, then 0x06.
   - Required: both return EAFFFFFE with if_fault=1. A following fetch of 0x00 gives if_fault=0.
5. Load during sweep:
   - Stimulus: ld_en with ld_addr=2 ld_data=32'h1234_5678 while busy=1.
   - Required: the write is dropped; after busy falls, a fetch of 0x08 returns EAFFFFFE.
6. Mid-operation reset:
   - Stimulus: program mem[1], issue a fetch, and assert reset on the response cycle.
   - Required: if_valid drops immediately and busy=1. After release the sweep runs 16 cycles, then a fetch of 0x04 returns EAFFFFFE.
